if_unit: RTL and testbench

IF_UNIT -- requirements
Module: if_unit

---
 rtl/if_pkg.sv | 22 ++
 rtl/pc_next.sv | 28 ++
 rtl/if_unit.sv | 120 ++++++++++++
 tb/tb_if_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch unit: FSM encoding, opcodes, offset widths.
package if_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_WAIT   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } if_state_t;

    localparam logic [5:0]  OP_J       = 6'b100100;
    localparam logic [5:0]  OP_BEQ     = 6'b100110;
    localparam int unsigned OP_MSB     = 30;
    localparam int unsigned OP_LSB     = 25;
    localparam int unsigned J_OFF_W    = 24;
    localparam int unsigned BEQ_OFF_W  = 14;
    localparam int unsigned TOTAL_W    = 16;
    localparam int unsigned PC_CALC_W  = 32;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: jump, taken branch, or sequential, wrapped to MemSize bits.
module pc_next
    import if_pkg::*;
#(
    parameter int unsigned MemSize = 10
) (
    input  logic [MemSize-1:0] i_pc,
    input  logic [5:0]         i_op,
    input  logic [J_OFF_W-1:0] i_off,
    input  logic               i_taken,
    output logic [MemSize-1:0] o_next_pc
);

    logic [PC_CALC_W-1:0] w_off;

    // Select the signed PC displacement; sequential flow is +1
    always_comb begin
        w_off = PC_CALC_W'(1);
        if (i_op == OP_J) begin
            w_off = {{(PC_CALC_W-J_OFF_W){i_off[J_OFF_W-1]}}, i_off};
        end else if ((i_op == OP_BEQ) && i_taken) begin
            w_off = {{(PC_CALC_W-BEQ_OFF_W){i_off[BEQ_OFF_W-1]}}, i_off[BEQ_OFF_W-1:0]};
        end
    end

    assign o_next_pc = MemSize'(PC_CALC_W'(i_pc) + w_off);

endmodule

// File: rtl/if_unit.sv
// Instruction-fetch unit: fetches from IM, holds ir until the controller steps,
// then advances PC (sequential / J / BEQ) until total_ir instructions retire.
// Optional macro INS_CNT_EN adds the saturating Ins_cnt output.
module if_unit
    import if_pkg::*;
#(
    parameter int unsigned MemSize  = 10,
    parameter int unsigned DataSize = 32,
    parameter int unsigned IM_START = 'h7F,
    parameter int unsigned InsSize  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [TOTAL_W-1:0]  total_ir,
    input  logic [DataSize-1:0] im_rdata,
    input  logic                step,
    input  logic                branch_taken,
    output logic [MemSize-1:0]  PC,
    output logic [DataSize-1:0] ir,
    output logic                ir_valid,
    output logic                enable_im,
    output logic                enable_im_fetch,
    output logic                exe_ir_done
`ifdef INS_CNT_EN
    ,
    output logic [InsSize-1:0]  Ins_cnt
`endif
);

    if_state_t            r_state;
    if_state_t            w_state_next;
    logic [MemSize-1:0]   r_pc;
    logic [DataSize-1:0]  r_ir;
    logic                 r_ir_valid;
    logic                 r_en;
    logic                 r_done;
    logic                 r_br;
    logic [TOTAL_W-1:0]   r_cnt;
    logic [TOTAL_W-1:0]   w_cnt_inc;
    logic [MemSize-1:0]   w_pc_next;

    assign w_cnt_inc = r_cnt + TOTAL_W'(1);

    pc_next #(
        .MemSize (MemSize)
    ) u_pc_next (
        .i_pc      (r_pc),
        .i_op      (r_ir[OP_MSB:OP_LSB]),
        .i_off     (r_ir[J_OFF_W-1:0]),
        .i_taken   (r_br),
        .o_next_pc (w_pc_next)
    );

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = (total_ir == TOTAL_W'(0)) ? S_DONE : S_FETCH;
            S_FETCH:  w_state_next = S_LATCH;
            S_LATCH:  w_state_next = (im_rdata == '0) ? S_DONE : S_WAIT;
            S_WAIT:   if (step) w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = (w_cnt_inc == total_ir) ? S_DONE : S_FETCH;
            S_DONE:   w_state_next = S_DONE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= MemSize'(IM_START);
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_en       <= (w_state_next == S_FETCH);
            r_done     <= (w_state_next == S_DONE);
            r_ir_valid <= (w_state_next == S_WAIT) || (w_state_next == S_UPDATE);
            if (r_state == S_LATCH) begin
                r_ir <= im_rdata;
            end
            if ((r_state == S_WAIT) && step) begin
                r_br <= branch_taken;
            end
            if (r_state == S_UPDATE) begin
                r_pc  <= w_pc_next;
                r_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef INS_CNT_EN
    logic [InsSize-1:0] r_ins_cnt;

    // Saturating retired-instruction counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ins_cnt <= '0;
        end else if ((r_state == S_UPDATE) && (r_ins_cnt != '1)) begin
            r_ins_cnt <= r_ins_cnt + InsSize'(1);
        end
    end

    assign Ins_cnt = r_ins_cnt;
`endif

    assign PC              = r_pc;
    assign ir              = r_ir;
    assign ir_valid        = r_ir_valid;
    assign enable_im       = r_en;
    assign enable_im_fetch = r_en;
    assign exe_ir_done     = r_done;

endmodule

// File: tb/tb_if_unit.sv
// Bench for if_unit: IM model, behavioural expected-output model, per-cycle compare
// plus directed literal checks of PC flow, branches, wrap, done and reset.
`timescale 1ns/1ps
module tb_if_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] total_ir = 16'd0;
    logic [31:0] im_rdata;
    logic        step = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  PC;
    logic [31:0] ir;
    logic        ir_valid;
    logic        enable_im;
    logic        enable_im_fetch;
    logic        exe_ir_done;
`ifdef INS_CNT_EN
    logic [63:0] Ins_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    if_unit dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .total_ir        (total_ir),
        .im_rdata        (im_rdata),
        .step            (step),
        .branch_taken    (branch_taken),
        .PC              (PC),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .enable_im       (enable_im),
        .enable_im_fetch (enable_im_fetch),
        .exe_ir_done     (exe_ir_done)
`ifdef INS_CNT_EN
        ,
        .Ins_cnt         (Ins_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory: data appears one cycle after the read strobe
    always @(posedge clock) begin
        if (enable_im && enable_im_fetch) im_rdata <= mem[PC];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program phase plus architectural PC/ir/count
    localparam int P_IDLE = 0, P_FETCH = 1, P_LATCH = 2, P_WAIT = 3, P_UPDATE = 4, P_DONE = 5;
    int          phase;
    int          m_pc;
    logic [31:0] m_ir;
    int          m_cnt;
    bit          m_br;

    function automatic int sext(input logic [31:0] v, input int w);
        int r;
        r = int'(v & ((32'd1 << w) - 32'd1));
        if (v[w-1]) r = r - (1 << w);
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase = P_IDLE; m_pc = 'h7F; m_ir = 0; m_cnt = 0; m_br = 0;
        end else begin
            case (phase)
                P_IDLE:   if (start) phase = (total_ir == 0) ? P_DONE : P_FETCH;
                P_FETCH:  phase = P_LATCH;
                P_LATCH:  begin
                    m_ir  = mem[m_pc];
                    phase = (m_ir == 0) ? P_DONE : P_WAIT;
                end
                P_WAIT:   if (step) begin m_br = branch_taken; phase = P_UPDATE; end
                P_UPDATE: begin
                    int off;
                    off = 1;
                    if (m_ir[30:25] == 6'b100100) off = sext(m_ir, 24);
                    else if (m_ir[30:25] == 6'b100110 && m_br) off = sext(m_ir, 14);
                    m_pc  = (((m_pc + off) % 1024) + 1024) % 1024;
                    m_cnt = m_cnt + 1;
                    phase = (m_cnt == int'(total_ir)) ? P_DONE : P_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            chk("m_pc",       64'(PC),              64'(m_pc));
            chk("m_ir",       64'(ir),              64'(m_ir));
            chk("m_ir_valid", 64'(ir_valid),        64'(phase == P_WAIT || phase == P_UPDATE));
            chk("m_en_im",    64'(enable_im),       64'(phase == P_FETCH));
            chk("m_en_fetch", 64'(enable_im_fetch), 64'(phase == P_FETCH));
            chk("m_done",     64'(exe_ir_done),     64'(phase == P_DONE));
`ifdef INS_CNT_EN
            chk("m_ins_cnt",  Ins_cnt,              64'(m_cnt));
`endif
        end
    end

    task automatic pulse_start();
        @(negedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic do_step(input logic br);
        @(negedge clock); #1 step = 1'b1; branch_taken = br;
        @(posedge clock); #1 step = 1'b0; branch_taken = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (ir_valid === 1'b1) return;
            @(posedge clock); #1;
        end
        chk("wait_ir_valid_timeout", 64'(ir_valid), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clock); #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    initial begin
        clear_mem();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_pc",    64'(PC),          64'h07F);
        chk("rst_ir",    64'(ir),          64'h0);
        chk("rst_valid", 64'(ir_valid),    64'h0);
        chk("rst_en",    64'(enable_im),   64'h0);
        chk("rst_done",  64'(exe_ir_done), 64'h0);
        reset = 1'b1;

        // Program 1: ADD, taken BEQ back by 2, ADD; three retirements
        mem['h07F] = 32'h0000_1234;
        mem['h080] = 32'h4C00_3FFE;
        mem['h07E] = 32'h0000_0055;
        total_ir   = 16'd3;
        pulse_start();
        chk("start_fetch_en", 64'(enable_im_fetch), 64'd1);
        chk("start_fetch_pc", 64'(PC),              64'h07F);
        chk("start_valid0",   64'(ir_valid),        64'd0);
        @(posedge clock); #1;
        chk("fetch_one_cycle", 64'(enable_im_fetch), 64'd0);
        @(posedge clock); #1;
        chk("valid_2cyc",     64'(ir_valid), 64'd1);
        chk("ir_add",         64'(ir),       64'h0000_1234);
        do_step(1'b0);
        chk("add_pc",         64'(PC), 64'h080);
        wait_valid();
        chk("ir_beq",         64'(ir), 64'h4C00_3FFE);
        do_step(1'b1);
        chk("beq_taken_pc",   64'(PC), 64'h07E);
        wait_valid();
        do_step(1'b0);
        chk("done_set",       64'(exe_ir_done), 64'd1);
        chk("done_pc",        64'(PC),          64'h07F);
        chk("done_valid0",    64'(ir_valid),    64'd0);
`ifdef INS_CNT_EN
        chk("ins_cnt3",       Ins_cnt,          64'd3);
`endif
        pulse_start();
        do_step(1'b1);
        repeat (3) @(posedge clock);
        #1;
        chk("done_hold_pc",   64'(PC),          64'h07F);
        chk("done_hold_ir",   64'(ir),          64'h0000_0055);
        chk("done_hold_flag", 64'(exe_ir_done), 64'd1);
        chk("done_no_fetch",  64'(enable_im),   64'd0);

        // Program 2: not-taken BEQ, jump to top of IM, wrapping jump, zero word
        do_reset();
        clear_mem();
        mem['h07F] = 32'h0000_1234;
        mem['h080] = 32'h4C00_3FFE;
        mem['h081] = 32'h4800_037E;
        mem['h3FF] = 32'h4800_0200;
        total_ir   = 16'd10;
        pulse_start();
        wait_valid();
        do_step(1'b0);
        chk("p2_add_pc",      64'(PC), 64'h080);
        wait_valid();
        do_step(1'b0);
        chk("beq_nt_pc",      64'(PC), 64'h081);
        wait_valid();
        do_step(1'b0);
        chk("j_fwd_pc",       64'(PC), 64'h3FF);
        wait_valid();
        do_step(1'b0);
        chk("j_wrap_pc",      64'(PC), 64'h1FF);
        repeat (3) @(posedge clock);
        #1;
        chk("zero_done",      64'(exe_ir_done), 64'd1);
        chk("zero_valid0",    64'(ir_valid),    64'd0);
        chk("zero_pc",        64'(PC),          64'h1FF);

        // Reset asserted mid-fetch
        do_reset();
        clear_mem();
        mem['h07F] = 32'h0000_1234;
        total_ir   = 16'd2;
        pulse_start();
        chk("mf_fetching",    64'(enable_im), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mf_rst_en",      64'(enable_im),       64'd0);
        chk("mf_rst_fetch",   64'(enable_im_fetch), 64'd0);
        chk("mf_rst_pc",      64'(PC),              64'h07F);
        chk("mf_rst_ir",      64'(ir),              64'h0);
        chk("mf_rst_valid",   64'(ir_valid),        64'd0);
        chk("mf_rst_done",    64'(exe_ir_done),     64'd0);
        @(negedge clock); #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("mf_discard",     64'(ir_valid), 64'd0);
        chk("mf_idle_ir",     64'(ir),       64'h0);
        pulse_start();
        wait_valid();
        chk("mf_restart_ir",  64'(ir), 64'h0000_1234);

        // total_ir == 0 finishes immediately on start
        do_reset();
        total_ir = 16'd0;
        pulse_start();
        chk("zero_total_done", 64'(exe_ir_done), 64'd1);
        chk("zero_total_en",   64'(enable_im),   64'd0);
        repeat (2) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
